// File: rtl/mdio_c22_arbiter.sv
// Round-robin arbiter that shares one Clause-22 MDIO shift engine between NREQ
// requesters. Only one frame is in flight at a time. A watchdog aborts frames the
// engine never completes, and a minimum idle gap is enforced between frames.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for gap expiry, engine idle and a pending request
// ISSUE  | frame fields latched, pulse eng_start, clear watchdog
// WAIT   | frame on the wire, waiting for eng_done or watchdog expiry
// RESP   | deliver response to owner, advance round-robin pointer, load gap
module mdio_c22_arbiter #(
    parameter int NREQ        = 3,
    parameter int TIMEOUT_CYC = 2048,
    parameter int GAP_CYC     = 20
) (
    input  logic                 clk_25m,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ-1:0]      req_write_i,
    input  logic [5*NREQ-1:0]    req_phy_i,
    input  logic [5*NREQ-1:0]    req_reg_i,
    input  logic [16*NREQ-1:0]   req_wdata_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [15:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [2:0]           grant_id_o,
    output logic                 eng_start_o,
    output logic                 eng_write_o,
    output logic [4:0]           eng_phy_o,
    output logic [4:0]           eng_reg_o,
    output logic [15:0]          eng_wdata_o,
    output logic                 eng_abort_o,
    input  logic                 eng_busy_i,
    input  logic                 eng_done_i,
    input  logic [15:0]          eng_rdata_i
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [2:0]          rr_ptr_q;
    logic [GW-1:0]       gap_cnt_q;
    logic [TW-1:0]       timer_q;
    logic [NREQ-1:0]     req_ready_q;
    logic [NREQ-1:0]     rsp_valid_q;
    logic [15:0]         rsp_rdata_q;
    logic                rsp_err_q;
    logic [2:0]          grant_id_q;
    logic                eng_start_q;
    logic                eng_write_q;
    logic [4:0]          eng_phy_q;
    logic [4:0]          eng_reg_q;
    logic [15:0]         eng_wdata_q;
    logic                eng_abort_q;

    logic                win_found_d;
    logic [2:0]          win_idx_d;
    int                  scan_idx;
    logic [NREQ-1:0]     scan_vec;

    logic [NREQ-1:0]     sel_write_vec;
    logic [5*NREQ-1:0]   sel_phy_vec;
    logic [5*NREQ-1:0]   sel_reg_vec;
    logic [16*NREQ-1:0]  sel_wdata_vec;

    // Round-robin search: first pending requester at or above rr_ptr, wrapping at NREQ.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        scan_idx    = 0;
        scan_vec    = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            scan_vec = req_valid_i >> scan_idx;
            if (!win_found_d && scan_vec[0]) begin
                win_found_d = 1'b1;
                win_idx_d   = 3'(scan_idx);
            end
        end
    end

    // Align the winner's frame fields to bit 0 so they can be latched directly.
    always_comb begin
        sel_write_vec = req_write_i >> win_idx_d;
        sel_phy_vec   = req_phy_i   >> (5 * win_idx_d);
        sel_reg_vec   = req_reg_i   >> (5 * win_idx_d);
        sel_wdata_vec = req_wdata_i >> (16 * win_idx_d);
    end

    // Arbitration FSM with registered outputs, watchdog and inter-frame gap counter.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gap_cnt_q   <= '0;
            timer_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            grant_id_q  <= '0;
            eng_start_q <= 1'b0;
            eng_write_q <= 1'b0;
            eng_phy_q   <= '0;
            eng_reg_q   <= '0;
            eng_wdata_q <= '0;
            eng_abort_q <= 1'b0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;
            if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - GW'(1);

            case (state_q)
                S_IDLE: begin
                    // The last gap decrement overlaps the grant decision, so the
                    // registered req_ready lands exactly GAP_CYC idle cycles after RESP.
                    if (gap_cnt_q <= GW'(1) && !eng_busy_i && win_found_d) begin
                        req_ready_q <= ONE << win_idx_d;
                        grant_id_q  <= win_idx_d;
                        eng_write_q <= sel_write_vec[0];
                        eng_phy_q   <= sel_phy_vec[4:0];
                        eng_reg_q   <= sel_reg_vec[4:0];
                        eng_wdata_q <= sel_wdata_vec[15:0];
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    eng_start_q <= 1'b1;
                    timer_q     <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_q + TW'(1);
                    // eng_done takes priority over a watchdog expiry in the same cycle.
                    if (eng_done_i) begin
                        rsp_valid_q <= ONE << grant_id_q;
                        rsp_rdata_q <= eng_write_q ? 16'h0000 : eng_rdata_i;
                        rsp_err_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        eng_abort_q <= 1'b1;
                        rsp_valid_q <= ONE << grant_id_q;
                        rsp_rdata_q <= 16'h0000;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (grant_id_q == 3'(NREQ - 1)) rr_ptr_q <= '0;
                    else                            rr_ptr_q <= grant_id_q + 3'd1;
                    gap_cnt_q <= GW'(GAP_CYC);
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign grant_id_o  = grant_id_q;
    assign eng_start_o = eng_start_q;
    assign eng_write_o = eng_write_q;
    assign eng_phy_o   = eng_phy_q;
    assign eng_reg_o   = eng_reg_q;
    assign eng_wdata_o = eng_wdata_q;
    assign eng_abort_o = eng_abort_q;

endmodule

// File: tb/tb_mdio_c22_arbiter.sv
// Testbench for mdio_c22_arbiter: directed scenarios plus randomized request mixes,
// compared against a cycle-count reference model of grant order, timing and responses.
module tb_mdio_c22_arbiter;

    localparam int NREQ = 3;
    localparam int TO   = 2048;
    localparam int GAP  = 20;

    logic                clk_25m = 1'b0;
    logic                rst_n   = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_write;
    logic [5*NREQ-1:0]   req_phy;
    logic [5*NREQ-1:0]   req_reg;
    logic [16*NREQ-1:0]  req_wdata;
    logic [NREQ-1:0]     rsp_valid;
    logic [15:0]         rsp_rdata;
    logic                rsp_err;
    logic [2:0]          grant_id;
    logic                eng_start;
    logic                eng_write;
    logic [4:0]          eng_phy;
    logic [4:0]          eng_reg;
    logic [15:0]         eng_wdata;
    logic                eng_abort;
    logic                eng_busy  = 1'b0;
    logic                eng_done  = 1'b0;
    logic [15:0]         eng_rdata = '0;

    logic                w_m   [NREQ];
    logic [4:0]          phy_m [NREQ];
    logic [4:0]          reg_m [NREQ];
    logic [15:0]         wd_m  [NREQ];

    int n_pass   = 0;
    int n_total  = 0;
    int cyc      = 0;
    int ptr_m    = 0;
    int last_rsp = -1000;
    int arm_cyc  = 0;

    mdio_c22_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
        .clk_25m     (clk_25m),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_phy_i   (req_phy),
        .req_reg_i   (req_reg),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .grant_id_o  (grant_id),
        .eng_start_o (eng_start),
        .eng_write_o (eng_write),
        .eng_phy_o   (eng_phy),
        .eng_reg_o   (eng_reg),
        .eng_wdata_o (eng_wdata),
        .eng_abort_o (eng_abort),
        .eng_busy_i  (eng_busy),
        .eng_done_i  (eng_done),
        .eng_rdata_i (eng_rdata)
    );

    always #20 clk_25m = ~clk_25m;

    always @(posedge clk_25m) cyc <= cyc + 1;

    always_comb begin
        req_write = '0;
        req_phy   = '0;
        req_reg   = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_write[i]        = w_m[i];
            req_phy[5*i +: 5]   = phy_m[i];
            req_reg[5*i +: 5]   = reg_m[i];
            req_wdata[16*i +: 16] = wd_m[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (m[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [63:0] all_outs();
        return {9'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, eng_start,
                eng_write, eng_phy, eng_reg, eng_wdata, eng_abort};
    endfunction

    // Invariants: at most one ready / one response, never in the same cycle.
    always @(negedge clk_25m) begin
        if (rst_n) begin
            check("ready_onehot0", 64'($onehot0(req_ready)), 1);
            check("rsp_onehot0", 64'($onehot0(rsp_valid)), 1);
            check("ready_rsp_excl", 64'((|req_ready) && (|rsp_valid)), 0);
        end
    end

    initial begin
        #(100000 * 40);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Raise a new request set; newly raised requesters get fresh random frame fields.
    task automatic set_valid(input logic [NREQ-1:0] m);
        for (int i = 0; i < NREQ; i++) begin
            if (m[i] && !req_valid[i]) begin
                w_m[i]   = 1'($urandom);
                phy_m[i] = 5'($urandom);
                reg_m[i] = 5'($urandom);
                wd_m[i]  = 16'($urandom);
            end
        end
        req_valid = m;
        arm_cyc   = cyc;
    endtask

    task automatic do_reset(input logic [NREQ-1:0] m);
        @(negedge clk_25m);
        rst_n     = 1'b0;
        req_valid = '0;
        eng_busy  = 1'b0;
        eng_done  = 1'b0;
        #1;
        check("reset_outputs_async", all_outs(), 0);
        repeat (3) begin
            @(negedge clk_25m);
            check("reset_no_rsp", rsp_valid, 0);
        end
        check("reset_outputs_hold", all_outs(), 0);
        set_valid(m);
        rst_n    = 1'b1;
        ptr_m    = 0;
        last_rsp = -1000;
    endtask

    task automatic grant_phase(output int g, output int s);
        bit seen;
        g    = pick(req_valid, ptr_m);
        seen = 1'b0;
        for (int k = 0; k < 3 * TO; k++) begin
            if (req_ready !== '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_25m);
        end
        check("ready_seen", 64'(seen), 1);
        check("ready_cycle", 64'(cyc), 64'(imax(last_rsp + GAP + 1, arm_cyc + 1)));
        check("ready_vec", req_ready, 64'(NREQ'(1) << g));
        check("grant_id", grant_id, 64'(g));
        check("eng_fields", {eng_write, eng_phy, eng_reg, eng_wdata},
              {w_m[g], phy_m[g], reg_m[g], wd_m[g]});
        req_valid[g] = 1'b0;
        @(negedge clk_25m);
        check("eng_start", eng_start, 1);
        check("ready_pulse", req_ready, 0);
        s        = cyc;
        eng_busy = 1'b1;
    endtask

    task automatic resp_phase(input int g, input int s, input int lat, input bit no_done,
                              input logic [15:0] rd);
        bit seen;
        logic [16:0] exp_rsp;
        if (no_done) begin
            seen = 1'b0;
            for (int k = 0; k < TO + 50; k++) begin
                @(negedge clk_25m);
                if (rsp_valid !== '0) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rsp_seen", 64'(seen), 1);
            check("rsp_cycle_to", 64'(cyc), 64'(s + TO));
            check("abort_on_to", eng_abort, 1);
            exp_rsp = {1'b1, 16'h0000};
        end else begin
            repeat (lat) @(negedge clk_25m);
            eng_done  = 1'b1;
            eng_rdata = rd;
            @(negedge clk_25m);
            eng_done  = 1'b0;
            eng_rdata = 16'($urandom);
            check("rsp_cycle_done", 64'(cyc), 64'(s + lat + 1));
            check("no_abort", eng_abort, 0);
            exp_rsp = {1'b0, (w_m[g] ? 16'h0000 : rd)};
        end
        eng_busy = 1'b0;
        check("rsp_vec", rsp_valid, 64'(NREQ'(1) << g));
        check("rsp_data_err", {rsp_err, rsp_rdata}, exp_rsp);
        ptr_m    = (g + 1) % NREQ;
        last_rsp = cyc;
        @(negedge clk_25m);
        check("rsp_pulse", rsp_valid, 0);
        check("abort_pulse", eng_abort, 0);
        check("rsp_hold", {rsp_err, rsp_rdata}, exp_rsp);
    endtask

    initial begin
        int g;
        int s;
        bit bad;
        int order[4] = '{0, 2, 0, 2};

        for (int i = 0; i < NREQ; i++) begin
            w_m[i]   = 1'b0;
            phy_m[i] = '0;
            reg_m[i] = '0;
            wd_m[i]  = '0;
        end

        // Reset state, then requester 1 alone: read phy 2 reg 1, done after 800 cycles.
        do_reset('0);
        set_valid(3'b010);
        w_m[1]   = 1'b0;
        phy_m[1] = 5'd2;
        reg_m[1] = 5'd1;
        grant_phase(g, s);
        resp_phase(g, s, 800, 1'b0, 16'h796D);

        // Requesters 0 and 2 together after reset: alternating grants, gap respected.
        do_reset(3'b101);
        for (int it = 0; it < 4; it++) begin
            grant_phase(g, s);
            resp_phase(g, s, int'($urandom_range(5, 40)), 1'b0, 16'($urandom));
            check("rr_order", grant_id, 64'(order[it]));
            set_valid(req_valid | NREQ'(NREQ'(1) << g));
        end
        req_valid = '0;

        // Write from requester 2 that the engine never completes: watchdog abort.
        set_valid(3'b100);
        w_m[2]  = 1'b1;
        wd_m[2] = 16'h1200;
        grant_phase(g, s);
        resp_phase(g, s, 0, 1'b1, 16'h0000);

        // Read whose eng_done lands on the watchdog cycle: done wins, no abort.
        set_valid(3'b001);
        w_m[0] = 1'b0;
        grant_phase(g, s);
        resp_phase(g, s, TO - 1, 1'b0, 16'hA5C3);

        // Engine busy in IDLE blocks the grant until it drops.
        eng_busy = 1'b1;
        set_valid(3'b001);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk_25m);
            if (req_ready !== '0 || eng_start !== 1'b0) bad = 1'b1;
        end
        check("busy_blocks_grant", 64'(bad), 0);
        eng_busy = 1'b0;
        arm_cyc  = cyc;
        grant_phase(g, s);
        resp_phase(g, s, int'($urandom_range(1, 30)), 1'b0, 16'($urandom));

        // Random request mixes; bits dropped before a grant are simply not served.
        repeat (12) begin
            set_valid(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
            grant_phase(g, s);
            resp_phase(g, s, int'($urandom_range(1, 60)), 1'b0, 16'($urandom));
        end

        // Reset during WAIT: outputs clear asynchronously, lowest valid index wins after.
        req_valid = '0;
        set_valid(3'b100);
        grant_phase(g, s);
        repeat (5) @(negedge clk_25m);
        do_reset(3'b110);
        grant_phase(g, s);
        check("post_reset_grant", grant_id, 1);
        resp_phase(g, s, int'($urandom_range(1, 30)), 1'b0, 16'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
